// File: rtl/rk86_crt_pixel_out.sv
`timescale 1ns/1ps
// rk86_crt_pixel_out: char-rate timing (crt_ce/hrtc/vrtc) for the RK86 CRT controller plus font lookup and pixel serialiser.
// Latency: a cell's pixels appear exactly one character cell after the controller presents that cell.
// Backpressure: none, free-running raster; the controller is paced by crt_ce. Build option: RK86_COLOR_EN enables colour rgb.
module rk86_crt_pixel_out #(
    parameter int CLK_DIV      = 2,
    parameter int CHAR_W       = 6,
    parameter int H_TOTAL      = 78,
    parameter int H_ACTIVE     = 64,
    parameter int H_SYNC_START = 66,
    parameter int H_SYNC_END   = 72,
    parameter int V_TOTAL      = 312,
    parameter int V_ACTIVE     = 250,
    parameter int V_SYNC_START = 280,
    parameter int V_SYNC_END   = 284
) (
    input  logic       clk,
    input  logic       reset,
    output logic       crt_ce,
    output logic       hrtc,
    output logic       vrtc,
    input  logic [6:0] ochar,
    input  logic [3:0] oline,
    input  logic       lten,
    input  logic       vsp,
    input  logic       rvv,
    input  logic       hilight,
    input  logic [1:0] gattr,
    output logic [9:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pix,
    output logic       hl,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (CHAR_W  > 1) ? $clog2(CHAR_W)  : 1;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PX_LAST  = PW'(CHAR_W - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [DW-1:0] div_q, div_n;
    logic [PW-1:0] px_q, px_n;
    logic [HW-1:0] hcnt_q, hcnt_n;
    logic [VW-1:0] vcnt_q, vcnt_n;
    logic          div_last, px_last, h_last, v_last, b_nxt, cell_start;

    assign div_last   = (div_q == DIV_LAST);
    assign px_last    = (px_q == PX_LAST);
    assign h_last     = (hcnt_q == H_LAST);
    assign v_last     = (vcnt_q == V_LAST);
    assign cell_start = (div_q == '0) && (px_q == '0);
    assign b_nxt      = (div_n == DIV_LAST) && (px_n == PX_LAST);

    // Next raster position: div carries into px, px into hcnt, hcnt into vcnt.
    always_comb begin
        div_n  = div_q;
        px_n   = px_q;
        hcnt_n = hcnt_q;
        vcnt_n = vcnt_q;
        if (div_last) begin
            div_n = '0;
            if (px_last) begin
                px_n = '0;
                if (h_last) begin
                    hcnt_n = '0;
                    vcnt_n = v_last ? '0 : vcnt_q + 1'b1;
                end else begin
                    hcnt_n = hcnt_q + 1'b1;
                end
            end else begin
                px_n = px_q + 1'b1;
            end
        end else begin
            div_n = div_q + 1'b1;
        end
    end

    // Raster counters; crt_ce marks the last clk of each cell, retrace flags change only then.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            px_q   <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            crt_ce <= 1'b0;
            hrtc   <= 1'b0;
            vrtc   <= 1'b0;
        end else begin
            div_q  <= div_n;
            px_q   <= px_n;
            hcnt_q <= hcnt_n;
            vcnt_q <= vcnt_n;
            crt_ce <= b_nxt;
            if (crt_ce) begin
                hrtc <= (int'(hcnt_n) >= H_SYNC_START) && (int'(hcnt_n) < H_SYNC_END);
                vrtc <= (int'(vcnt_n) >= V_SYNC_START) && (int'(vcnt_n) < V_SYNC_END);
            end
        end
    end

    logic              rd_s1, rd_s2;
    logic              lat_lten, lat_vsp, lat_rvv, lat_hil, lat_blank, lat_hs, lat_vs;
    logic [1:0]        lat_gattr;
    logic [CHAR_W-1:0] glyph, pat_q, shift_q;
    logic [1:0]        gattr_q;

    // Glyph row after suppress / light-enable overrides, before reverse video.
    always_comb begin
        glyph = rom_data[CHAR_W-1:0];
        if (lat_vsp) begin
            glyph = '0;
        end else if (lat_lten) begin
            glyph = '1;
        end
    end

    // Capture the controller's cell on its first clk, then the ROM row two clks later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            rom_addr  <= '0;
            lat_lten  <= 1'b0;
            lat_vsp   <= 1'b0;
            lat_rvv   <= 1'b0;
            lat_hil   <= 1'b0;
            lat_gattr <= '0;
            lat_blank <= 1'b1;
            lat_hs    <= 1'b0;
            lat_vs    <= 1'b0;
            pat_q     <= '0;
        end else begin
            rd_s1 <= cell_start;
            rd_s2 <= rd_s1;
            if (cell_start) begin
                rom_addr  <= {ochar, oline[2:0]};
                lat_lten  <= lten;
                lat_vsp   <= vsp;
                lat_rvv   <= rvv;
                lat_hil   <= hilight;
                lat_gattr <= gattr;
                lat_blank <= (int'(hcnt_q) >= H_ACTIVE) || (int'(vcnt_q) >= V_ACTIVE);
                lat_hs    <= hrtc;
                lat_vs    <= vrtc;
            end
            if (rd_s2) begin
                pat_q <= glyph ^ {CHAR_W{lat_rvv}};
            end
        end
    end

    // Shifter loads at the cell boundary with its attributes, then shifts MSB-first each pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            blank   <= 1'b1;
            hl      <= 1'b0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            gattr_q <= '0;
        end else if (crt_ce) begin
            shift_q <= pat_q;
            blank   <= lat_blank;
            hl      <= lat_hil;
            hsync   <= lat_hs;
            vsync   <= lat_vs;
            gattr_q <= lat_gattr;
        end else if (div_last) begin
            shift_q <= shift_q << 1;
        end
    end

    assign pix = shift_q[CHAR_W-1] & ~blank;

`ifdef RK86_COLOR_EN
    logic [2:0] colour;
    assign colour = {hl, gattr_q};
    // A lit pixel with no colour bits would be invisible, so it is shown white.
    assign rgb = pix ? ((colour == 3'b000) ? 3'b111 : colour) : 3'b000;
`else
    assign rgb = {3{pix}};
`endif

    // Font bits beyond the cell width, glyph row bit 3 and (mono build) gattr have no use here.
    logic unused_bits;
    assign unused_bits = ^{rom_data, oline[3], gattr_q};

endmodule

// File: doc/rk86_crt_pixel_out.md
Name: rk86_crt_pixel_out

Overview:
Downstream stage of the RK86 CRT controller. It generates the character-rate clock enable, `hrtc` and `vrtc` that drive the controller. It then consumes the controller's per-character outputs (`ochar`, `oline`, `lten`, `vsp`, `rvv`, `hilight`, `gattr`), looks the glyph up in an external font ROM, and serialises it to pixels with attributes applied. Its outputs go to the board video DAC / scan-doubler.

Parameters:
CLK_DIV, 2, clk cycles per pixel (>=1)
CHAR_W, 6, pixels per character cell (1..8); CHAR_W*CLK_DIV must be >=4
H_TOTAL, 78, character cells per scanline
H_ACTIVE, 64, visible cells per scanline
H_SYNC_START, 66, first cell with hrtc=1
H_SYNC_END, 72, first cell after hrtc pulse
V_TOTAL, 312, scanlines per frame
V_ACTIVE, 250, visible scanlines
V_SYNC_START, 280, first scanline with vrtc=1
V_SYNC_END, 284, first scanline after vrtc pulse

Ports:
clk  in  1  system clock, only clock
reset  in  1  synchronous, active-high
crt_ce  out  1  one-clk char-rate enable to the CRT controller's ce
hrtc  out  1  horizontal retrace to the controller
vrtc  out  1  vertical retrace to the controller
ochar  in  7  character code from the controller
oline  in  4  glyph row from the controller
lten  in  1  light enable (force row on)
vsp  in  1  video suppress (force row off)
rvv  in  1  reverse video
hilight  in  1  highlight attribute
gattr  in  2  general attribute bits
rom_addr  out  10  font ROM address {ochar, oline[2:0]}
rom_data  in  8  font ROM data, valid 1 clk after rom_addr
pix  out  1  serial pixel
hl  out  1  highlight for current pixel
blank  out  1  1 outside active area
hsync  out  1  hrtc aligned to pix
vsync  out  1  vrtc aligned to pix
rgb  out  3  colour pixel (see Optional Feature)

Behaviour:
- Counters: div 0..CLK_DIV-1, px 0..CHAR_W-1, hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1. Each wraps to 0 and carries into the next. px advances when div==CLK_DIV-1.
- Cell boundary B is the clk where div==CLK_DIV-1 and px==CHAR_W-1. crt_ce=1 for exactly that clk, otherwise 0.
- hrtc = registered (hcnt in [H_SYNC_START,H_SYNC_END)). vrtc = registered (vcnt in [V_SYNC_START,V_SYNC_END)). Both are updated only at B, so they are stable while the controller samples on crt_ce.
- Controller outputs are valid from B+1. At B+1 the block registers rom_addr={ochar,oline[2:0]} and latches lten, vsp, rvv, hilight, gattr and the cell's blank/hrtc/vrtc state. rom_data is captured at B+3.
- Pattern is computed from the captured data:
  - vsp=1: 0
  - else lten=1: all ones
  - else: rom_data[CHAR_W-1:0]
  - then XOR with all ones if rvv=1.
- The shifter loads the pattern at the next B, so pixel output lags its cell by exactly one cell. Shifting is MSB-first (bit CHAR_W-1 first), advancing when div==CLK_DIV-1.
- pix = shifter MSB & ~blank. hl, blank, hsync and vsync are loaded with the shifter, so they are aligned to pix.
- blank = (hcnt>=H_ACTIVE)|(vcnt>=V_ACTIVE) for the cell being shown.
- Reset: all counters 0; crt_ce, hrtc, vrtc, pix, hl, hsync, vsync, rgb = 0; rom_addr = 0; shifter = 0; blank = 1.
  - The first crt_ce occurs CLK_DIV*CHAR_W clks after reset deasserts.
  - Reset asserted mid-frame takes effect on the next clk: counters restart and the current pattern is discarded.
- Simultaneous wraps (last px of the last cell of the last line) roll div, px, hcnt and vcnt to 0 on the same clk. vrtc/hrtc are recomputed from the new counts.
- Parameters are not range-checked in RTL. The bench checks only legal sets (SYNC_START<SYNC_END<=TOTAL, ACTIVE<=SYNC_START).

Optional Feature:
- Macro RK86_COLOR_EN.
- Defined: rgb = pix ? {hl, gattr} : 3'b000, using the attributes latched with the shifter load; a colour of 3'b000 with pix=1 maps to 3'b111.
- Undefined: rgb = {3{pix}}; gattr is ignored.
- All ports exist in both builds.

Test Plan:
- Reset, then free-run with defaults -> crt_ce period 12 clks; hrtc=1 for cells 66..71 (72 clks per line); vrtc=1 for lines 280..283; frame period 312*78*12 clks.
- Hold ochar=7'h41, oline=3, ROM returns 8'b00101101 for addr {41h,3}, all attrs 0 -> one cell after capture, pix sequence 1,0,1,1,0,1 with each bit held 2 clks.
- Same glyph with rvv=1 -> pix 0,1,0,0,1,0. With vsp=1 -> all 0. With lten=1 and vsp=0 -> all 1. With vsp=1 and lten=1 -> all 0.
- Drive a lit glyph at hcnt 63 and 64 -> pix shown for the cell-63 data; blank=1 and pix=0 for the cell-64 data; hsync rises aligned with the cell-66 data at pix.
- Assert reset for 1 clk mid-line at hcnt=30 -> next clk all counters 0, pix=0, blank=1; crt_ce resumes after exactly 12 clks.
- RK86_COLOR_EN defined, gattr=2'b10, hilight=1, glyph bit 1 -> rgb=3'b110; bit 0 -> 3'b000. Macro undefined, same stimulus -> rgb=3'b111 / 3'b000.
